register_file: RTL and testbench
================================

Name: register_file

Overview:
- RV32I integer register file: 32 x 32-bit registers (x0..x31), two combinational read ports, one synchronous write port.
- Sits directly upstream of the ALU B-operand select. rd2_o drives that mux's rd2_i input and also supplies store data. rd1_o drives the ALU A operand.
- Provides write-through bypass so a value written in cycle N is visible on read ports in the same cycle.
- Provides a debug read port so benches can inspect any register without disturbing the datapath.

Parameters:
- XLEN, 32, register and data width in bits.
- REG_COUNT, 32, number of architectural registers; must equal 2**ADDR_W.
- ADDR_W, 5, register address width in bits.

Ports:
- clk_i  input  1  clock; all writes occur on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- a1_i  input  ADDR_W  read port 1 address (rs1).
- a2_i  input  ADDR_W  read port 2 address (rs2).
- a3_i  input  ADDR_W  write address (rd).
- we3_i  input  1  write enable.
- wd3_i  input  XLEN  write data.
- dbg_a_i  input  ADDR_W  debug read address.
- rd1_o  output  XLEN  read data 1.
- rd2_o  output  XLEN  read data 2; feeds the ALU source-B mux.
- dbg_rd_o  output  XLEN  debug read data.

Behaviour:
- Reset:
  - rst_ni low asynchronously clears all registers x1..x31 to 32'h0000_0000, regardless of clk_i.
  - While rst_ni is low, writes are ignored.
  - rd1_o, rd2_o and dbg_rd_o read 0 for every address during reset.
- Write:
  - On the rising edge of clk_i, with rst_ni high, we3_i=1 and a3_i!=0, register[a3_i] <= wd3_i.
  - we3_i=0 means no state change.
  - A write to a3_i=0 is silently discarded; x0 has no storage and always reads 0.
- Read:
  - Purely combinational, zero-cycle latency: rdN_o = register[aN_i].
  - Address 0 always returns 0, including under bypass.
- Bypass (write-through):
  - When we3_i=1, a3_i!=0, rst_ni=1 and aN_i==a3_i, rdN_o = wd3_i in the same cycle, before the edge.
  - Applies independently to rd1_o, rd2_o and dbg_rd_o.
  - After the edge, the stored value equals wd3_i, so the output is continuous.
- Simultaneous events:
  - a1_i==a2_i==a3_i with a write: both read ports show wd3_i.
  - Reset asserted mid-cycle while a write is pending: the write is lost and the register reads 0.
  - Reset released near a clock edge: the first write is honoured on the first rising edge where rst_ni is sampled high.
- Width rules:
  - No sign or zero extension; data passes through unmodified.
  - Addresses are exactly ADDR_W bits, so there is no out-of-range case.
- There is no FSM. Sequential state is the 31-entry array only.

Test Plan:
1. Reset: drive rst_ni=0 after writing x5=32'hDEAD_BEEF, then read a1_i=5 and dbg_a_i=5 -> rd1_o=0 and dbg_rd_o=0 immediately, without a clock edge.
2. Basic write/read: write x1=32'd1 and x2=32'hFFFF_FFFF on consecutive edges, then set a1_i=1, a2_i=2 -> rd1_o=32'd1, rd2_o=32'hFFFF_FFFF.
3. x0 hardwired: we3_i=1, a3_i=0, wd3_i=32'h1234_5678, clock, then read a1_i=0 -> rd1_o=0. Also with a2_i=0 during the write cycle -> rd2_o=0 (no bypass to x0).
4. Bypass: x3 holds 32'd7. Drive we3_i=1, a3_i=3, wd3_i=32'd9, a1_i=a2_i=3 before the edge -> rd1_o=rd2_o=32'd9 within 1 ns. After the edge with we3_i=0 -> still 32'd9.
5. Write disable: we3_i=0, a3_i=4, wd3_i=32'hAAAA_AAAA, clock -> dbg_rd_o for a4 stays 0.
6. Integration with the ALU source-B mux: x6=32'd0, immediate 32'd1. alu_src=0 -> src_b=32'd0; alu_src=1 -> src_b=32'd1.

Source files
------------

// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN registers, x0 hardwired to zero,
// two combinational read ports plus a debug port, all with write-through bypass.
module register_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] a1_i,
    input  logic [ADDR_W-1:0] a2_i,
    input  logic [ADDR_W-1:0] a3_i,
    input  logic              we3_i,
    input  logic [XLEN-1:0]   wd3_i,
    input  logic [ADDR_W-1:0] dbg_a_i,
    output logic [XLEN-1:0]   rd1_o,
    output logic [XLEN-1:0]   rd2_o,
    output logic [XLEN-1:0]   dbg_rd_o
);

    // x0 has no storage; only x1..x(REG_COUNT-1) are flops.
    logic [XLEN-1:0] regs [1:REG_COUNT-1];

    logic write_active;
    assign write_active = rst_ni && we3_i && (a3_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we3_i && (a3_i != '0)) begin
            regs[a3_i] <= wd3_i;
        end
    end

    // Port 0 = rs1, port 1 = rs2, port 2 = debug; all share the same read/bypass rule.
    logic [ADDR_W-1:0] rd_addr [3];
    logic [XLEN-1:0]   rd_data [3];

    assign rd_addr[0] = a1_i;
    assign rd_addr[1] = a2_i;
    assign rd_addr[2] = dbg_a_i;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (rst_ni && (rd_addr[p] != '0)) begin
                if (write_active && (rd_addr[p] == a3_i)) begin
                    rd_data[p] = wd3_i;
                end else begin
                    rd_data[p] = regs[rd_addr[p]];
                end
            end
        end
    end

    assign rd1_o    = rd_data[0];
    assign rd2_o    = rd_data[1];
    assign dbg_rd_o = rd_data[2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file, including a bench-side
// model of the ALU source-B mux that rd2_o feeds.
module tb_register_file;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;

    logic              clk_i;
    logic              rst_ni;
    logic [ADDR_W-1:0] a1_i;
    logic [ADDR_W-1:0] a2_i;
    logic [ADDR_W-1:0] a3_i;
    logic              we3_i;
    logic [XLEN-1:0]   wd3_i;
    logic [ADDR_W-1:0] dbg_a_i;
    logic [XLEN-1:0]   rd1_o;
    logic [XLEN-1:0]   rd2_o;
    logic [XLEN-1:0]   dbg_rd_o;

    logic              alu_src;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   src_b;

    int compared   = 0;
    int mismatched = 0;

    register_file #(.XLEN(XLEN), .REG_COUNT(32), .ADDR_W(ADDR_W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .a1_i     (a1_i),
        .a2_i     (a2_i),
        .a3_i     (a3_i),
        .we3_i    (we3_i),
        .wd3_i    (wd3_i),
        .dbg_a_i  (dbg_a_i),
        .rd1_o    (rd1_o),
        .rd2_o    (rd2_o),
        .dbg_rd_o (dbg_rd_o)
    );

    assign src_b = alu_src ? imm : rd2_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge and settle 1 ns before being sampled.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] a3,
                                 input logic [XLEN-1:0] wd, input logic [ADDR_W-1:0] a1,
                                 input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] dbg);
        @(negedge clk_i);
        we3_i   = we;
        a3_i    = a3;
        wd3_i   = wd;
        a1_i    = a1;
        a2_i    = a2;
        dbg_a_i = dbg;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        we3_i   = 1'b0;
        a1_i    = '0;
        a2_i    = '0;
        a3_i    = '0;
        wd3_i   = '0;
        dbg_a_i = '0;
        alu_src = 1'b0;
        imm     = 32'd1;

        // Reset state, including bypass suppression while reset is held.
        applyStimulus(1'b1, 5'd9, 32'h5555_5555, 5'd9, 5'd31, 5'd9);
        checkOutput("reset_rd1_bypass_blocked", rd1_o, 32'h0);
        checkOutput("reset_rd2_x31", rd2_o, 32'h0);
        checkOutput("reset_dbg", dbg_rd_o, 32'h0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9);
        rst_ni = 1'b1;
        #1;
        checkOutput("reset_write_ignored", rd1_o, 32'h0);

        // Test 1: async reset clears a stored value with no clock edge.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
        checkOutput("x5_written", dbg_rd_o, 32'hDEAD_BEEF);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("async_reset_rd1", rd1_o, 32'h0);
        checkOutput("async_reset_dbg", dbg_rd_o, 32'h0);
        // Write pending when reset asserts is lost.
        applyStimulus(1'b1, 5'd7, 32'h1111_2222, 5'd7, 5'd0, 5'd7);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd5);
        rst_ni = 1'b1;
        #1;
        checkOutput("pending_write_lost", rd1_o, 32'h0);
        checkOutput("x5_stays_cleared", dbg_rd_o, 32'h0);

        // Test 2: basic writes on consecutive edges.
        applyStimulus(1'b1, 5'd1, 32'd1, 5'd0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd2, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd0);
        checkOutput("read_x1", rd1_o, 32'd1);
        checkOutput("read_x2", rd2_o, 32'hFFFF_FFFF);

        // Boundary register x31.
        applyStimulus(1'b1, 5'd31, 32'h8000_0001, 5'd0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd1, 5'd0);
        checkOutput("read_x31", rd1_o, 32'h8000_0001);
        checkOutput("x1_unaffected", rd2_o, 32'd1);

        // Test 3: x0 write discarded and never bypassed.
        applyStimulus(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_no_bypass_rd2", rd2_o, 32'h0);
        checkOutput("x0_no_bypass_dbg", dbg_rd_o, 32'h0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_reads_zero", rd1_o, 32'h0);

        // Test 4: bypass on both read ports and the debug port.
        applyStimulus(1'b1, 5'd3, 32'd7, 5'd0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        checkOutput("x3_holds_7", rd1_o, 32'd7);
        applyStimulus(1'b1, 5'd3, 32'd9, 5'd3, 5'd3, 5'd3);
        checkOutput("bypass_rd1", rd1_o, 32'd9);
        checkOutput("bypass_rd2", rd2_o, 32'd9);
        checkOutput("bypass_dbg", dbg_rd_o, 32'd9);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        checkOutput("after_edge_rd1", rd1_o, 32'd9);
        checkOutput("after_edge_rd2", rd2_o, 32'd9);

        // Test 5: write disabled leaves x4 untouched.
        applyStimulus(1'b0, 5'd4, 32'hAAAA_AAAA, 5'd4, 5'd0, 5'd4);
        checkOutput("we0_no_bypass", rd1_o, 32'h0);
        clockEdge();
        checkOutput("we0_no_write", dbg_rd_o, 32'h0);

        // Test 6: rd2_o into the ALU source-B mux.
        applyStimulus(1'b1, 5'd6, 32'd0, 5'd0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd6, 5'd0);
        alu_src = 1'b0;
        #1;
        checkOutput("src_b_reg", src_b, 32'd0);
        alu_src = 1'b1;
        #1;
        checkOutput("src_b_imm", src_b, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
